// File: rtl/xof_byte_repack.sv
// rtl/xof_byte_repack.sv - 64-bit XOF lane to 48-bit Din gearbox feeding sample_u
module xof_byte_repack #(
    parameter int N_OUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        u_mod,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        out_en,
    output logic [47:0] Din,
    output logic        Din_flag,
    output logic        done
);
    localparam int WCW = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_buf [16];
    logic [7:0]     w_buf_nxt [16];
    logic [4:0]     r_fill, w_fill_nxt, w_k, w_base;
    logic           r_mode;
    logic [WCW-1:0] r_wcnt;
    logic [47:0]    r_din, w_din_pack;
    logic           r_din_flag, r_done;
    logic           w_accept, w_emit, w_last;

    assign in_ready = (r_state == S_RUN) && (r_fill <= 5'd8);
    assign w_k      = r_mode ? 5'd6 : 5'd2;
    assign w_accept = in_ready && in_valid && !start;
    assign w_emit   = (r_state == S_RUN) && (r_fill >= w_k) && out_en && !start;
    assign w_last   = (r_wcnt == WCW'(N_OUT - 1));

    assign Din      = r_din;
    assign Din_flag = r_din_flag;
    assign done     = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_emit && w_last) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Pop K head bytes first, then append the new lane behind what remains.
    always_comb begin
        w_base     = r_fill - (w_emit ? w_k : 5'd0);
        w_fill_nxt = w_base + (w_accept ? 5'd8 : 5'd0);
        for (int i = 0; i < 16; i++) begin
            w_buf_nxt[i] = w_emit ? r_buf[4'(i + int'(w_k))] : r_buf[4'(i)];
        end
        if (w_accept) begin
            for (int j = 0; j < 8; j++) begin
                w_buf_nxt[4'(int'(w_base) + j)] = in_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        if (r_mode) w_din_pack = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4], r_buf[5]};
        else        w_din_pack = {32'h0, r_buf[0], r_buf[1]};
    end

    always_ff @(posedge clk) begin
        r_buf <= w_buf_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill     <= 5'd0;
            r_wcnt     <= '0;
            r_mode     <= 1'b0;
            r_din      <= 48'h0;
            r_din_flag <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE) && !start;
            if (start) begin
                r_fill     <= 5'd0;
                r_wcnt     <= '0;
                r_mode     <= u_mod;
                r_din      <= 48'h0;
                r_din_flag <= 1'b0;
            end else begin
                // Leftover bytes are dropped once the run leaves RUN.
                r_fill     <= (r_state == S_RUN) ? w_fill_nxt : 5'd0;
                r_din_flag <= w_emit;
                r_din      <= w_emit ? w_din_pack : 48'h0;
                if (w_emit) r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xof_byte_repack.sv
// tb/tb_xof_byte_repack.sv - directed self-checking bench for xof_byte_repack
module tb_xof_byte_repack;
    localparam int N_OUT = 4;

    logic        clk = 1'b0;
    logic        rst, start, u_mod, in_valid, out_en;
    logic [63:0] in_data;
    logic        in_ready, Din_flag, done;
    logic [47:0] Din;
    int          checks = 0;
    int          failures = 0;

    xof_byte_repack #(.N_OUT(N_OUT)) dut (
        .clk(clk), .rst(rst), .start(start), .u_mod(u_mod),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_en(out_en), .Din(Din), .Din_flag(Din_flag), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lane(input int n);
        logic [63:0] l;
        for (int i = 0; i < 8; i++) l[8*i +: 8] = 8'(8*n + i);
        return l;
    endfunction

    function automatic logic [47:0] exp_m1(input int w);
        logic [47:0] e;
        for (int k = 0; k < 6; k++) e[47-8*k -: 8] = 8'(6*w + k);
        return e;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; u_mod = 1'b0; in_valid = 1'b0; out_en = 1'b1; in_data = '0;
        repeat (2) tick;
        checks++; if (Din !== 48'h0) begin failures++; $display("FAIL reset_din got=%h exp=0", Din); end
        checks++; if (Din_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", Din_flag); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (dut.r_fill !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", dut.r_fill); end
        rst = 1'b0;
        tick;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_mode1_pair;
        start = 1'b1; u_mod = 1'b1; tick;
        start = 1'b0; u_mod = 1'b0;
        in_valid = 1'b1; in_data = 64'h0706050403020100; tick;
        checks++; if (Din_flag !== 1'b0) begin failures++; $display("FAIL m1_latency got=%b exp=0", Din_flag); end
        in_data = 64'h0F0E0D0C0B0A0908; tick;
        checks++; if (Din_flag !== 1'b1 || Din !== 48'h000102030405) begin failures++; $display("FAIL m1_word0 got=%b/%h exp=1/000102030405", Din_flag, Din); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL m1_ready_full got=%b exp=0", in_ready); end
        in_valid = 1'b0; tick;
        checks++; if (Din_flag !== 1'b1 || Din !== 48'h060708090A0B) begin failures++; $display("FAIL m1_word1 got=%b/%h exp=1/060708090a0b", Din_flag, Din); end
        tick;
        checks++; if (Din_flag !== 1'b0 || Din !== 48'h0) begin failures++; $display("FAIL m1_bubble got=%b/%h exp=0/0", Din_flag, Din); end
        checks++; if (dut.r_fill !== 5'd4) begin failures++; $display("FAIL m1_fill got=%0d exp=4", dut.r_fill); end
    endtask

    task automatic test_mode0;
        logic [47:0] exp_w [4];
        exp_w[0] = 48'h0001; exp_w[1] = 48'h0203; exp_w[2] = 48'h0405; exp_w[3] = 48'h0607;
        start = 1'b1; u_mod = 1'b0; tick;
        start = 1'b0; in_valid = 1'b1; in_data = 64'h0706050403020100; tick;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (Din_flag !== 1'b1 || Din !== exp_w[k]) begin failures++; $display("FAIL m0_word%0d got=%b/%h exp=1/%h", k, Din_flag, Din, exp_w[k]); end
        end
        tick;
        checks++; if (done !== 1'b1 || Din_flag !== 1'b0) begin failures++; $display("FAIL m0_done got=%b/%b exp=1/0", done, Din_flag); end
        tick;
        checks++; if (done !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL m0_after_done got=%b/%b exp=0/0", done, in_ready); end
    endtask

    task automatic test_continuous;
        int idx = 0, widx = 0, ndone = 0, idx_at_done = -1;
        logic acc;
        start = 1'b1; u_mod = 1'b1; tick;
        start = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = 1'b1; in_data = lane(idx); out_en = 1'b1;
            acc = in_ready && in_valid;
            tick;
            if (acc) idx++;
            if (Din_flag) begin
                checks++; if (Din !== exp_m1(widx)) begin failures++; $display("FAIL cont_word%0d got=%h exp=%h", widx, Din, exp_m1(widx)); end
                widx++;
            end
            if (done) begin
                ndone++; idx_at_done = idx;
                checks++; if (Din_flag !== 1'b0) begin failures++; $display("FAIL cont_done_flag got=%b exp=0", Din_flag); end
            end
        end
        in_valid = 1'b0;
        checks++; if (widx !== N_OUT) begin failures++; $display("FAIL cont_words got=%0d exp=%0d", widx, N_OUT); end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL cont_done_count got=%0d exp=1", ndone); end
        checks++; if (idx !== idx_at_done) begin failures++; $display("FAIL cont_lanes_after_done got=%0d exp=%0d", idx, idx_at_done); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cont_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_stall;
        int idx = 0, widx = 0, ndone = 0, stall = 0;
        logic acc, oe;
        start = 1'b1; u_mod = 1'b1; tick;
        start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = 1'b1; in_data = lane(idx);
            out_en = (stall > 0) ? 1'b0 : 1'b1;
            oe = out_en; acc = in_ready && in_valid;
            tick;
            if (acc) idx++;
            if (stall > 0) begin
                stall--;
                checks++; if (dut.r_fill > 5'd16) begin failures++; $display("FAIL stall_fill got=%0d exp<=16", dut.r_fill); end
            end
            if (Din_flag) begin
                checks++; if (!oe || Din !== exp_m1(widx)) begin failures++; $display("FAIL stall_word%0d got=%h oe=%b exp=%h", widx, Din, oe, exp_m1(widx)); end
                if (widx == 0) stall = 5;
                widx++;
            end
            if (done) ndone++;
        end
        in_valid = 1'b0; out_en = 1'b1;
        checks++; if (widx !== N_OUT || ndone !== 1) begin failures++; $display("FAIL stall_totals got=%0d/%0d exp=%0d/1", widx, ndone, N_OUT); end
    endtask

    task automatic test_restart;
        logic [47:0] exp_w [4];
        exp_w[0] = 48'hF0F1; exp_w[1] = 48'hF2F3; exp_w[2] = 48'hF4F5; exp_w[3] = 48'hF6F7;
        start = 1'b1; u_mod = 1'b1; tick;
        start = 1'b0; in_valid = 1'b1; in_data = 64'h1716151413121110; tick;
        in_valid = 1'b0; tick;
        checks++; if (Din_flag !== 1'b1 || Din !== 48'h101112131415) begin failures++; $display("FAIL rs_first got=%b/%h exp=1/101112131415", Din_flag, Din); end
        start = 1'b1; u_mod = 1'b0; tick;
        start = 1'b0;
        checks++; if (Din_flag !== 1'b0 || dut.r_wcnt !== '0 || dut.r_fill !== 5'd0) begin failures++; $display("FAIL rs_clear got=%b/%0d/%0d exp=0/0/0", Din_flag, dut.r_wcnt, dut.r_fill); end
        in_valid = 1'b1; in_data = 64'hF7F6F5F4F3F2F1F0; tick;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++; if (Din_flag !== 1'b1 || Din !== exp_w[k]) begin failures++; $display("FAIL rs_word%0d got=%b/%h exp=1/%h", k, Din_flag, Din, exp_w[k]); end
        end
        tick;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rs_done got=%b exp=1", done); end
    endtask

    task automatic test_async_reset;
        start = 1'b1; u_mod = 1'b0; tick;
        start = 1'b0; in_valid = 1'b1; in_data = lane(3); tick;
        in_valid = 1'b0; tick;
        checks++; if (Din_flag !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b/%b exp=1/1", Din_flag, in_ready); end
        #3 rst = 1'b1;
        #1;
        checks++; if (Din !== 48'h0 || Din_flag !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL ar_outputs got=%h/%b/%b exp=0/0/0", Din, Din_flag, in_ready); end
        #1 rst = 1'b0;
        in_valid = 1'b1; in_data = lane(5);
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++; if (Din_flag !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL ar_quiet%0d got=%b/%b exp=0/0", k, Din_flag, in_ready); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_mode1_pair;
        test_mode0;
        test_continuous;
        test_stall;
        test_restart;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
